// File: rtl/c432_key_loader_if.sv
// rtl/c432_key_loader_if.sv - serial key stream interface for the c432 key loader
// Purpose: groups the key-load handshake between the key source (master) and loader (slave).
// Signals:
//   start     - one-cycle pulse beginning a key load (master -> slave)
//   key_bit   - serial key/checksum data, LSB first (master -> slave)
//   key_valid - key_bit is valid this cycle (master -> slave)
//   key_ready - loader can accept a serial bit (slave -> master)
interface c432_key_loader_if;
   logic start;
   logic key_bit;
   logic key_valid;
   logic key_ready;

   modport master (output start, output key_bit, output key_valid, input key_ready);
   modport slave  (input start, input key_bit, input key_valid, output key_ready);
endinterface

// File: rtl/c432_key_loader.sv
// rtl/c432_key_loader.sv - serial key loader with nibble-XOR checksum and failure lockout
// Purpose: shifts in a KEY_W-bit unlock key followed by a CHK_W-bit checksum, verifies it,
//          and commits it to a parallel key register for the locked c432 netlist.
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset
//   key_if     - serial key stream (start, key_bit, key_valid in; key_ready out)
//   key_out    - committed key: [31:0] = X_1..X_32, [35:32] = p1..p4; zero unless verified
//   key_ok     - key_out holds a verified key
//   busy       - load in progress (SHIFT or CHECK)
//   fail_cnt   - consecutive checksum failures
//   locked_out - sticky lockout flag, cleared only by rst
module c432_key_loader #(
   parameter int KEY_W    = 36,
   parameter int CHK_W    = 4,
   parameter int MAX_FAIL = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   c432_key_loader_if.slave     key_if,
   output logic [KEY_W-1:0]     key_out,
   output logic                 key_ok,
   output logic                 busy,
   output logic [3:0]           fail_cnt,
   output logic                 locked_out
);

   localparam int TOT_W = KEY_W + CHK_W;
   localparam int CNT_W = $clog2(TOT_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(TOT_W - 1);
   localparam logic [3:0]       FAIL_LIMIT = 4'(MAX_FAIL);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT,
      S_CHECK,
      S_ARMED,
      S_LOCKOUT
   } state_t;

   state_t             state_q, state_d;
   logic [TOT_W-1:0]   sr_q, sr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [KEY_W-1:0]   key_q, key_d;
   logic               ok_q, ok_d;
   logic               busy_q, busy_d;
   logic [3:0]         fail_q, fail_d;
   logic               lock_q, lock_d;

   logic [CHK_W-1:0]   chk_calc;
   logic               chk_match;
   logic [3:0]         fail_inc;

   // Checksum is the XOR of every CHK_W-bit slice of the key field.
   always_comb begin
      chk_calc = '0;
      for (int i = 0; i < KEY_W / CHK_W; i++) begin
         chk_calc = chk_calc ^ sr_q[i*CHK_W +: CHK_W];
      end
      chk_match = (chk_calc == sr_q[KEY_W +: CHK_W]);
   end

   assign fail_inc = fail_q + 4'd1;

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      ok_d    = ok_q;
      fail_d  = fail_q;
      lock_d  = lock_q;

      unique case (state_q)
         S_IDLE: begin
            if (key_if.start) begin
               sr_d    = '0;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            // A restart wins over a bit sampled in the same cycle.
            if (key_if.start) begin
               sr_d  = '0;
               cnt_d = '0;
            end else if (key_if.key_valid) begin
               sr_d[cnt_q] = key_if.key_bit;
               cnt_d       = cnt_q + 1'b1;
               if (cnt_q == LAST_BIT) begin
                  state_d = S_CHECK;
               end
            end
         end
         S_CHECK: begin
            if (chk_match) begin
               key_d   = sr_q[KEY_W-1:0];
               ok_d    = 1'b1;
               fail_d  = 4'd0;
               state_d = S_ARMED;
            end else begin
               key_d   = '0;
               ok_d    = 1'b0;
               fail_d  = fail_inc;
               if (fail_inc == FAIL_LIMIT) begin
                  lock_d  = 1'b1;
                  state_d = S_LOCKOUT;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_ARMED: begin
            // Drop the committed key on re-key so no partial key is ever presented.
            if (key_if.start) begin
               key_d   = '0;
               ok_d    = 1'b0;
               sr_d    = '0;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_LOCKOUT: begin
            key_d = '0;
            ok_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // busy is registered, so derive it from the state being entered.
      busy_d = (state_d == S_SHIFT) || (state_d == S_CHECK);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         key_q   <= '0;
         ok_q    <= 1'b0;
         busy_q  <= 1'b0;
         fail_q  <= 4'd0;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         key_q   <= key_d;
         ok_q    <= ok_d;
         busy_q  <= busy_d;
         fail_q  <= fail_d;
         lock_q  <= lock_d;
      end
   end

   assign key_if.key_ready = (state_q == S_SHIFT);
   assign key_out          = key_q;
   assign key_ok           = ok_q;
   assign busy             = busy_q;
   assign fail_cnt         = fail_q;
   assign locked_out       = lock_q;

endmodule

// File: tb/tb_c432_key_loader.sv
// tb/tb_c432_key_loader.sv - self-checking bench for c432_key_loader
module tb_c432_key_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic [35:0] key_out;
   logic        key_ok;
   logic        busy;
   logic [3:0]  fail_cnt;
   logic        locked_out;

   int total = 0;
   int bad   = 0;

   // Reference model: committed key, verified flag, failure count, lockout.
   logic [35:0] m_key;
   logic        m_ok;
   int          m_fail;
   logic        m_lock;

   always #5 clk = ~clk;

   c432_key_loader_if kif();

   c432_key_loader dut (
      .clk        (clk),
      .rst        (rst),
      .key_if     (kif),
      .key_out    (key_out),
      .key_ok     (key_ok),
      .busy       (busy),
      .fail_cnt   (fail_cnt),
      .locked_out (locked_out)
   );

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [3:0] nib_xor(input logic [35:0] k);
      int acc;
      acc = 0;
      for (int i = 0; i < 9; i++) acc = acc ^ int'((k >> (4 * i)) & 36'hF);
      return acc[3:0];
   endfunction

   task automatic do_reset(input string tag);
      rst = 1'b1;
      kif.start = 1'b0;
      kif.key_valid = 1'b0;
      kif.key_bit = 1'b0;
      tick;
      m_key = '0; m_ok = 1'b0; m_fail = 0; m_lock = 1'b0;
      total++;
      if ({key_out, key_ok, busy, fail_cnt, locked_out, kif.key_ready} !== 44'd0) begin
         bad++;
         $display("FAIL %s reset_outputs got key=%h ok=%b busy=%b fail=%0d lock=%b rdy=%b want all 0",
                  tag, key_out, key_ok, busy, fail_cnt, locked_out, kif.key_ready);
      end
      rst = 1'b0;
   endtask

   // mode 0: valid every cycle, 1: alternating gaps, 2: random gaps
   task automatic load(input logic [35:0] key, input logic [3:0] chk, input int mode, input string tag);
      logic [39:0] word;
      word = {chk, key};
      kif.start = 1'b1;
      kif.key_valid = 1'b0;
      kif.key_bit = 1'($urandom);
      tick;
      kif.start = 1'b0;
      if (!m_lock) begin
         m_key = '0;
         m_ok  = 1'b0;
      end
      total++;
      if ({busy, key_ok, kif.key_ready, key_out} !== {!m_lock, m_ok, !m_lock, m_key}) begin
         bad++;
         $display("FAIL %s after_start got busy=%b ok=%b rdy=%b key=%h want busy=%b ok=%b rdy=%b key=%h",
                  tag, busy, key_ok, kif.key_ready, key_out, !m_lock, m_ok, !m_lock, m_key);
      end
      for (int k = 0; k < 40; k++) begin
         if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) begin
            kif.key_valid = 1'b0;
            kif.key_bit = 1'($urandom);
            tick;
         end
         kif.key_valid = 1'b1;
         kif.key_bit = word[k];
         tick;
      end
      kif.key_valid = 1'b0;
      if (!m_lock) begin
         total++;
         if ({busy, key_ok, kif.key_ready} !== 3'b100) begin
            bad++;
            $display("FAIL %s check_cycle got busy=%b ok=%b rdy=%b want 1 0 0",
                     tag, busy, key_ok, kif.key_ready);
         end
      end
      tick;
      if (!m_lock) begin
         if (chk == nib_xor(key)) begin
            m_key = key; m_ok = 1'b1; m_fail = 0;
         end else begin
            m_key = '0; m_ok = 1'b0; m_fail = m_fail + 1;
            if (m_fail == 3) m_lock = 1'b1;
         end
      end
      total++;
      if ({key_out, key_ok, fail_cnt, locked_out, busy, kif.key_ready} !==
          {m_key, m_ok, 4'(m_fail), m_lock, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL %s result got key=%h ok=%b fail=%0d lock=%b busy=%b rdy=%b want key=%h ok=%b fail=%0d lock=%b busy=0 rdy=0",
                  tag, key_out, key_ok, fail_cnt, locked_out, busy, kif.key_ready,
                  m_key, m_ok, m_fail, m_lock);
      end
   endtask

   task automatic partial(input int nbits);
      kif.start = 1'b1;
      kif.key_valid = 1'b0;
      tick;
      kif.start = 1'b0;
      for (int k = 0; k < nbits; k++) begin
         kif.key_valid = 1'b1;
         kif.key_bit = 1'($urandom);
         tick;
      end
      kif.key_valid = 1'b0;
   endtask

   task automatic test_reset;
      do_reset("reset");
   endtask

   task automatic test_basic;
      load(36'h1_2345_6789, 4'h1, 0, "basic");
      total++;
      if (key_out !== 36'h1_2345_6789) begin
         bad++;
         $display("FAIL basic_const got=%h want=123456789", key_out);
      end
   endtask

   task automatic test_gaps;
      load(36'hF_FFFF_FFFF, 4'hF, 1, "gaps");
      total++;
      if (key_out !== 36'hF_FFFF_FFFF || key_ok !== 1'b1) begin
         bad++;
         $display("FAIL gaps_const got key=%h ok=%b want fffffffff 1", key_out, key_ok);
      end
   endtask

   task automatic test_lockout;
      do_reset("lockout_rst");
      for (int n = 1; n <= 3; n++) begin
         load(36'h0_0000_0001, 4'h0, 0, "lockout_bad");
         total++;
         if (fail_cnt !== 4'(n) || locked_out !== (n == 3)) begin
            bad++;
            $display("FAIL lockout_count got fail=%0d lock=%b want fail=%0d lock=%b",
                     fail_cnt, locked_out, n, (n == 3));
         end
      end
      load(36'h0_0000_0001, 4'h1, 0, "lockout_ignored");
      total++;
      if (key_out !== 36'd0 || kif.key_ready !== 1'b0 || locked_out !== 1'b1) begin
         bad++;
         $display("FAIL lockout_hold got key=%h rdy=%b lock=%b want 0 0 1", key_out, kif.key_ready, locked_out);
      end
   endtask

   task automatic test_rekey;
      do_reset("rekey_rst");
      load(36'h1_2345_6789, 4'h1, 0, "rekey_first");
      load(36'h0_0000_0001, 4'h1, 0, "rekey_second");
      total++;
      if (key_out !== 36'h0_0000_0001) begin
         bad++;
         $display("FAIL rekey_const got=%h want=000000001", key_out);
      end
   endtask

   task automatic test_restart;
      do_reset("restart_rst");
      partial(20);
      load(36'h1_2345_6789, 4'h1, 2, "restart");
   endtask

   task automatic test_rst_mid;
      do_reset("rstmid_rst");
      for (int n = 0; n < 3; n++) load(36'h0_0000_0001, 4'h0, 0, "rstmid_bad");
      do_reset("rst_in_lockout");
      partial(20);
      do_reset("rst_mid_shift");
      load(36'h1_2345_6789, 4'h1, 0, "rstmid_armed");
      do_reset("rst_in_armed");
      load(36'hF_FFFF_FFFF, 4'hF, 0, "rstmid_after");
   endtask

   task automatic test_random;
      logic [35:0] rk;
      logic [3:0]  rc;
      do_reset("random_rst");
      for (int n = 0; n < 16; n++) begin
         if (m_lock) do_reset("random_unlock");
         rk[31:0]  = $urandom;
         rk[35:32] = 4'($urandom);
         rc = ($urandom_range(0, 3) == 0) ? 4'($urandom) : nib_xor(rk);
         load(rk, rc, int'($urandom_range(0, 2)), "random");
      end
   endtask

   initial begin
      rst = 1'b1;
      kif.start = 1'b0;
      kif.key_valid = 1'b0;
      kif.key_bit = 1'b0;
      m_key = '0; m_ok = 1'b0; m_fail = 0; m_lock = 1'b0;
      @(negedge clk);
      test_reset;
      test_basic;
      test_gaps;
      test_lockout;
      test_rekey;
      test_restart;
      test_rst_mid;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
